lane_accumulator: RTL and testbench

//  Sequential successor of the combinational single-shot neuron-sum adder.

---
 rtl/lane_accumulator.sv | 159 +++++++++++++++
 tb/tb_lane_accumulator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_accumulator.sv
// Frame accumulator: sums NUM_LANES signed products per beat onto a bias through a
// two-stage pipeline and reports one saturated or wrapped result per frame.
module lane_accumulator #(
   parameter int NUM_LANES = 3,
   parameter int PROD_W    = 19,
   parameter int ACC_W     = 32,
   parameter int SATURATE  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [ACC_W-1:0]              bias,
   input  logic                          in_valid,
   input  logic                          in_last,
   input  logic [NUM_LANES*PROD_W-1:0]   in_data,
   output logic                          in_ready,
   output logic                          busy,
   output logic                          out_valid,
   output logic [ACC_W-1:0]              out_result,
   output logic                          out_overflow
);

   localparam int LS_W  = PROD_W + $clog2(NUM_LANES) + 1;
   // Wide enough for both operands so the lane sum is never truncated before the add.
   localparam int SUM_W = ((ACC_W >= LS_W) ? ACC_W : LS_W) + 1;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t                         state_q, state_d;
   logic [NUM_LANES*PROD_W-1:0]    beat_q, beat_d;
   logic                           beat_vld_q, beat_vld_d;
   logic signed [LS_W-1:0]         lane_sum_q, lane_sum_d;
   logic                           sum_vld_q, sum_vld_d;
   logic signed [ACC_W-1:0]        acc_q, acc_d;
   logic                           in_ready_q, in_ready_d;
   logic                           busy_q, busy_d;
   logic                           out_valid_q, out_valid_d;
   logic [ACC_W-1:0]               out_result_q, out_result_d;
   logic                           out_overflow_q, out_overflow_d;

   logic                           accept;
   logic signed [PROD_W-1:0]       lane_prod;
   logic signed [LS_W-1:0]         lane_total;
   logic signed [SUM_W-1:0]        acc_wide;
   logic [SUM_W-ACC_W:0]           acc_top;
   logic                           acc_ovf;
   logic [ACC_W-1:0]               acc_fit;

   assign accept = in_valid && in_ready_q;

   always_comb begin
      lane_prod  = '0;
      lane_total = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_prod  = beat_q[i*PROD_W +: PROD_W];
         lane_total = lane_total + LS_W'(lane_prod);
      end
   end

   // Overflow when the bits above the result's sign bit are not all copies of it.
   assign acc_wide = SUM_W'(acc_q) + SUM_W'(lane_sum_q);
   assign acc_top  = acc_wide[SUM_W-1:ACC_W-1];
   assign acc_ovf  = !((&acc_top) || !(|acc_top));
   assign acc_fit  = (acc_ovf && SATURATE != 0) ? (acc_wide[SUM_W-1] ? ACC_MIN : ACC_MAX)
                                                : acc_wide[ACC_W-1:0];

   always_comb begin
      // NOTE: every _d starts from its _q so no branch can leave a value unassigned and infer a latch.
      state_d        = state_q;
      beat_d         = beat_q;
      lane_sum_d     = lane_sum_q;
      acc_d          = acc_q;
      out_result_d   = out_result_q;
      out_overflow_d = out_overflow_q;
      out_valid_d    = 1'b0;
      beat_vld_d     = accept;
      sum_vld_d      = beat_vld_q;

      if (accept) begin
         beat_d = in_data;
      end
      if (beat_vld_q) begin
         lane_sum_d = lane_total;
      end
      if (sum_vld_q) begin
         acc_d = acc_fit;
         if (acc_ovf) begin
            out_overflow_d = 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d        = ACCUM;
               acc_d          = bias;
               out_overflow_d = 1'b0;
            end
         end
         ACCUM: begin
            if (accept && in_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!beat_vld_q && !sum_vld_q) begin
               state_d      = DONE;
               out_valid_d  = 1'b1;
               out_result_d = acc_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d = (state_d == ACCUM);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         beat_q         <= '0;
         beat_vld_q     <= 1'b0;
         lane_sum_q     <= '0;
         sum_vld_q      <= 1'b0;
         acc_q          <= '0;
         in_ready_q     <= 1'b0;
         busy_q         <= 1'b0;
         out_valid_q    <= 1'b0;
         out_result_q   <= '0;
         out_overflow_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q        <= state_d;
         beat_q         <= beat_d;
         beat_vld_q     <= beat_vld_d;
         lane_sum_q     <= lane_sum_d;
         sum_vld_q      <= sum_vld_d;
         acc_q          <= acc_d;
         in_ready_q     <= in_ready_d;
         busy_q         <= busy_d;
         out_valid_q    <= out_valid_d;
         out_result_q   <= out_result_d;
         out_overflow_q <= out_overflow_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign busy         = busy_q;
   assign out_valid    = out_valid_q;
   assign out_result   = out_result_q;
   assign out_overflow = out_overflow_q;

endmodule

// File: tb/tb_lane_accumulator.sv
// Bench for lane_accumulator: three instances (32-bit saturating, 20-bit saturating,
// 20-bit wrapping) share one stimulus stream and are compared every cycle to a frame-level model.
module tb_lane_accumulator;

   localparam int N  = 3;
   localparam int PW = 19;
   localparam int DW = N * PW;

   logic clk = 1'b0;
   logic rst, start, in_valid, in_last;
   logic [DW-1:0] in_data;
   logic [31:0] bias32;
   logic [19:0] bias20;
   logic rdy [3];
   logic bsy [3];
   logic ovld [3];
   logic ovf [3];
   logic signed [31:0] res_a;
   logic signed [19:0] res_b, res_c;

   int checks = 0;
   int errors = 0;
   longint cyc = 0;

   always #5 clk = ~clk;

   lane_accumulator #(.NUM_LANES(N), .PROD_W(PW), .ACC_W(32), .SATURATE(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .bias(bias32), .in_valid(in_valid),
      .in_last(in_last), .in_data(in_data), .in_ready(rdy[0]), .busy(bsy[0]),
      .out_valid(ovld[0]), .out_result(res_a), .out_overflow(ovf[0]));

   lane_accumulator #(.NUM_LANES(N), .PROD_W(PW), .ACC_W(20), .SATURATE(1)) dut_b (
      .clk(clk), .rst(rst), .start(start), .bias(bias20), .in_valid(in_valid),
      .in_last(in_last), .in_data(in_data), .in_ready(rdy[1]), .busy(bsy[1]),
      .out_valid(ovld[1]), .out_result(res_b), .out_overflow(ovf[1]));

   lane_accumulator #(.NUM_LANES(N), .PROD_W(PW), .ACC_W(20), .SATURATE(0)) dut_c (
      .clk(clk), .rst(rst), .start(start), .bias(bias20), .in_valid(in_valid),
      .in_last(in_last), .in_data(in_data), .in_ready(rdy[2]), .busy(bsy[2]),
      .out_valid(ovld[2]), .out_result(res_c), .out_overflow(ovf[2]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
      end
   endtask

   function automatic logic [63:0] dut_res(input int i);
      case (i)
         0:       return 64'(res_a);
         1:       return 64'(res_b);
         default: return 64'(res_c);
      endcase
   endfunction

   function automatic int acc_w(input int i);
      return (i == 0) ? 32 : 20;
   endfunction

   function automatic bit sat_of(input int i);
      return (i != 2);
   endfunction

   // ---------------- frame-level reference model ----------------
   longint m_acc [3];
   longint m_res [3];
   bit     m_ovf [3];
   bit     m_open = 1'b0;
   bit     m_active = 1'b0;
   bit     m_valid = 1'b0;
   longint done_edge = 0;

   function automatic longint lane_total(input logic [DW-1:0] d);
      longint t = 0;
      logic signed [PW-1:0] p;
      for (int j = 0; j < N; j++) begin
         p = d[j*PW +: PW];
         t += longint'(p);
      end
      return t;
   endfunction

   function automatic longint limit(input int w, input bit sat, input longint v, output bit ov);
      longint hi = (longint'(1) <<< (w - 1)) - 1;
      longint lo = -(longint'(1) <<< (w - 1));
      longint m  = longint'(1) <<< w;
      ov = (v > hi) || (v < lo);
      if (!ov) return v;
      if (sat) return (v > hi) ? hi : lo;
      v = v & (m - 1);
      if (v > hi) v = v - m;
      return v;
   endfunction

   always @(posedge clk) begin : model
      longint ls;
      bit o;
      cyc = cyc + 1;
      if (rst) begin
         m_open = 0; m_active = 0; m_valid = 0;
         for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_res[i] = 0; m_ovf[i] = 0;
         end
      end else if (m_valid) begin
         m_valid = 0;
         m_active = 0;
      end else if (!m_active) begin
         if (start) begin
            m_active = 1;
            m_open   = 1;
            m_acc[0] = longint'($signed(bias32));
            m_acc[1] = longint'($signed(bias20));
            m_acc[2] = longint'($signed(bias20));
            for (int i = 0; i < 3; i++) m_ovf[i] = 0;
         end
      end else if (m_open) begin
         if (in_valid) begin
            ls = lane_total(in_data);
            for (int i = 0; i < 3; i++) begin
               m_acc[i] = limit(acc_w(i), sat_of(i), m_acc[i] + ls, o);
               m_ovf[i] = m_ovf[i] | o;
            end
            if (in_last) begin
               m_open = 0;
               done_edge = cyc + 3;
            end
         end
      end else if (cyc == done_edge) begin
         m_valid = 1;
         for (int i = 0; i < 3; i++) m_res[i] = m_acc[i];
      end
   end

   // Overflow is only defined by the model once a frame has finished (DONE or IDLE).
   always @(negedge clk) begin
      if (cyc > 0) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("in_ready[%0d]", i), 64'(rdy[i]), 64'(m_open));
            check($sformatf("busy[%0d]", i), 64'(bsy[i]), 64'(m_active));
            check($sformatf("out_valid[%0d]", i), 64'(ovld[i]), 64'(m_valid));
            check($sformatf("out_result[%0d]", i), dut_res(i), 64'(m_res[i]));
            if (!m_active || m_valid)
               check($sformatf("out_overflow[%0d]", i), 64'(ovf[i]), 64'(m_ovf[i]));
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [63:0] got_res [3];
   logic        got_ovf [3];
   longint      got_lat;

   function automatic logic [DW-1:0] pack3(input int a, input int b, input int c);
      logic [DW-1:0] d;
      d[PW-1:0]      = PW'(a);
      d[2*PW-1:PW]   = PW'(b);
      d[3*PW-1:2*PW] = PW'(c);
      return d;
   endfunction

   function automatic logic [DW-1:0] rand_data(input int mode);
      logic [DW-1:0] d;
      int v;
      for (int j = 0; j < N; j++) begin
         if (mode == 1) v = int'($urandom_range(2000)) - 1000;
         else           v = int'($urandom);
         d[j*PW +: PW] = PW'(v);
      end
      return d;
   endfunction

   task automatic run_frame(input logic [31:0] b32, input logic [19:0] b20, input int nbeats,
                            input int gap_pct, input int mode, input logic [DW-1:0] fixed,
                            input bit poke);
      int b = 0;
      int guard = 0;
      longint acc_edge = 0;
      bit seen = 0;
      @(negedge clk);
      start = 1'b1; bias32 = b32; bias20 = b20; in_valid = 1'b0; in_last = 1'b0;
      while (b < nbeats && guard < 2000) begin
         @(negedge clk);
         guard++;
         start    = poke ? 1'($urandom_range(1)) : 1'b0;
         in_valid = ($urandom_range(99) >= gap_pct);
         in_data  = (mode == 0) ? fixed : rand_data(mode);
         in_last  = (b == nbeats - 1);
         if (in_valid && rdy[0] === 1'b1) begin
            b++;
            if (b == nbeats) acc_edge = cyc + 1;
         end
      end
      check("beats_accepted", 64'(b), 64'(nbeats));
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(1));
         in_last  = 1'($urandom_range(1));
         in_data  = rand_data(2);
         start    = poke ? 1'($urandom_range(1)) : 1'b0;
         if (ovld[0] === 1'b1) begin
            seen = 1;
            got_lat = cyc - acc_edge;
            for (int i = 0; i < 3; i++) begin
               got_res[i] = dut_res(i);
               got_ovf[i] = ovf[i];
            end
            start = poke;
         end
      end
      check("out_valid_seen", 64'(seen), 64'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_data = '0; bias32 = '0; bias20 = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(bsy[0]), 64'd0);
      check("reset_result", dut_res(0), 64'd0);
      rst = 1'b0;

      run_frame(32'd10, 20'd10, 1, 0, 0, pack3(1, 2, 3), 1'b0);
      check("t1_result", got_res[0], 64'd16);
      check("t1_latency", 64'(got_lat), 64'd3);
      check("t1_overflow", 64'(got_ovf[0]), 64'd0);

      run_frame(32'd0, 20'd0, 4, 0, 0, pack3(-5, 7, 100), 1'b0);
      check("t2_result", got_res[0], 64'd408);

      run_frame(32'd524278, 20'd524278, 1, 0, 0, pack3(5, 5, 5), 1'b0);
      check("t3_sat_result", got_res[1], 64'd524287);
      check("t3_sat_overflow", 64'(got_ovf[1]), 64'd1);
      check("t4_wrap_result", got_res[2], -64'sd524283);
      check("t4_wrap_overflow", 64'(got_ovf[2]), 64'd1);
      check("t3_wide_result", got_res[0], 64'd524293);
      check("t3_wide_overflow", 64'(got_ovf[0]), 64'd0);

      @(negedge clk);
      start = 1'b1; bias32 = 32'd5; bias20 = 20'd5;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_data = pack3(1, 1, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check("t6_in_ready", 64'(rdy[0]), 64'd0);
      check("t6_busy", 64'(bsy[0]), 64'd0);
      check("t6_out_valid", 64'(ovld[0]), 64'd0);
      check("t6_out_result", dut_res(0), 64'd0);
      check("t6_overflow", 64'(ovf[1]), 64'd0);
      repeat (6) @(negedge clk);
      check("t6_no_late_valid", 64'(ovld[0]), 64'd0);

      run_frame(32'd10, 20'd10, 1, 0, 0, pack3(1, 2, 3), 1'b0);
      check("t6_rerun_result", got_res[0], 64'd16);

      for (int f = 0; f < 40; f++) begin
         int sel;
         logic [19:0] b20;
         sel = int'($urandom_range(2));
         if (sel == 0)      b20 = 20'(524287 - $urandom_range(3000));
         else if (sel == 1) b20 = 20'(-524288 + $urandom_range(3000));
         else               b20 = 20'($urandom);
         run_frame($urandom, b20, int'($urandom_range(6, 1)), int'($urandom_range(60)),
                   int'($urandom_range(2, 1)), '0, 1'b1);
      end
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

endmodule
